coef_update_rx: RTL and testbench

FPGA-side receiver for the coefficient-update protocol the Nios II drives on its `update_control` (9 bits) and `update_value` (16 bits) PIO outputs. It detects each new update word, decodes the target axis, bank and tap, and buffers accepted words in a small FIFO. It then issues them over a valid/ready write port to the X/Y/Z FIR coefficient stores. It also returns sticky status to the CPU on an input PIO.

---
 rtl/coef_update_pkg.sv | 41 ++++
 rtl/coef_fifo.sv | 66 ++++++
 rtl/coef_update_rx.sv | 125 ++++++++++++
 tb/tb_coef_update_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coef_update_pkg.sv
`default_nettype none
// ============================================================================
// Package : coef_update_pkg
// Desc    : Shared field positions, encodings and FIFO entry type for the
//           coefficient-update protocol.
// Rev     : 1.0  initial release
// ============================================================================
package coef_update_pkg;

    localparam int CTL_W        = 9;
    localparam int CTL_TOG_BIT  = 8;
    localparam int CTL_AXIS_LSB = 6;
    localparam int CTL_BANK_LSB = 4;
    localparam int CTL_TAP_LSB  = 0;
    localparam int CTL_TAP_BITS = 4;

    localparam logic [1:0] AXIS_X   = 2'd0;
    localparam logic [1:0] AXIS_Y   = 2'd1;
    localparam logic [1:0] AXIS_Z   = 2'd2;
    localparam logic [1:0] AXIS_CMD = 2'd3;

    localparam logic [3:0] CMD_CLEAR_TAP = 4'd15;

    localparam int STAT_OVF_BIT  = 7;
    localparam int STAT_ERR_BIT  = 6;
    localparam int STAT_LVL_LSB  = 1;
    localparam int STAT_BUSY_BIT = 0;

    typedef struct packed {
        logic [1:0]  axis;
        logic [1:0]  bank;
        logic [3:0]  tap;
        logic [15:0] data;
    } coef_entry_t;

    function automatic logic [2:0] sat_level(input int unsigned lvl);
        return (lvl > 7) ? 3'd7 : lvl[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/coef_fifo.sv
`default_nettype none
// ============================================================================
// Module  : coef_fifo
// Desc    : Show-ahead FIFO with full/empty/level and simultaneous push/pop.
// Rev     : 1.0  initial release
// ============================================================================
module coef_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign level_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/coef_update_rx.sv
`default_nettype none
// ============================================================================
// Module  : coef_update_rx
// Desc    : Receives toggle-strobed coefficient updates from the CPU PIO,
//           queues them and issues valid/ready writes to the coefficient stores.
// Rev     : 1.0  initial release
// ============================================================================
module coef_update_rx
    import coef_update_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 16,
    parameter int TAP_W      = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [8:0]        update_control,
    input  logic [DATA_W-1:0] update_value,
    output logic              coef_wr_valid,
    input  logic              coef_wr_ready,
    output logic [1:0]        coef_wr_axis,
    output logic [1:0]        coef_wr_bank,
    output logic [TAP_W-1:0]  coef_wr_tap,
    output logic [DATA_W-1:0] coef_wr_data,
    output logic [7:0]        status
);

    localparam int ENT_W = 4 + TAP_W + DATA_W;
    localparam int AW    = $clog2(FIFO_DEPTH);

    logic [CTL_W-1:0]  ctl_q;
    logic [DATA_W-1:0] val_q;
    logic              tog_ref_q;
    logic              primed_q;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic [7:0]        status_q, status_d;

    logic              w_event;
    logic [1:0]        w_axis;
    logic [1:0]        w_bank;
    logic [3:0]        w_tap;
    logic              w_is_cmd;
    logic              w_push_req;
    logic              w_clear;
    logic              w_err_set;
    logic              w_ovf_set;
    logic              w_pop;
    logic [ENT_W-1:0]  w_push_data;
    logic [ENT_W-1:0]  w_head;
    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_level;

    // Sampling runs through reset so priming compares against a settled input.
    always_ff @(posedge clk_clk) begin
        ctl_q <= update_control;
        val_q <= update_value;
    end

    assign w_axis   = ctl_q[CTL_AXIS_LSB +: 2];
    assign w_bank   = ctl_q[CTL_BANK_LSB +: 2];
    assign w_tap    = ctl_q[CTL_TAP_LSB +: CTL_TAP_BITS];
    assign w_event  = primed_q && (ctl_q[CTL_TOG_BIT] != tog_ref_q);
    assign w_is_cmd = (w_axis == AXIS_CMD);

    assign w_push_req  = w_event && !w_is_cmd;
    assign w_clear     = w_event && w_is_cmd && (w_tap == CMD_CLEAR_TAP);
    assign w_err_set   = w_event && w_is_cmd && (w_tap != CMD_CLEAR_TAP);
    assign w_pop       = !w_empty && coef_wr_ready;
    assign w_ovf_set   = w_push_req && w_full && !w_pop;
    assign w_push_data = {w_axis, w_bank, TAP_W'(w_tap), val_q};

    coef_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk         (clk_clk),
        .rst         (reset_reset),
        .push_i      (w_push_req),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .level_o     (w_level)
    );

    always_comb begin
        ovf_d = w_clear ? 1'b0 : (ovf_q | w_ovf_set);
        err_d = w_clear ? 1'b0 : (err_q | w_err_set);

        status_d                                = 8'h00;
        status_d[STAT_OVF_BIT]                  = ovf_q;
        status_d[STAT_ERR_BIT]                  = err_q;
        status_d[STAT_LVL_LSB +: 3]             = sat_level(32'(w_level));
        status_d[STAT_BUSY_BIT]                 = !w_empty;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tog_ref_q <= 1'b0;
            primed_q  <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            status_q  <= 8'h00;
        end else begin
            tog_ref_q <= ctl_q[CTL_TOG_BIT];
            primed_q  <= 1'b1;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            status_q  <= status_d;
        end
    end

    // Stale RAM contents are masked so an idle port reads as all zeros.
    assign coef_wr_valid = !w_empty;
    assign coef_wr_axis  = w_empty ? 2'b00 : w_head[ENT_W-1 -: 2];
    assign coef_wr_bank  = w_empty ? 2'b00 : w_head[ENT_W-3 -: 2];
    assign coef_wr_tap   = w_empty ? '0    : w_head[DATA_W +: TAP_W];
    assign coef_wr_data  = w_empty ? '0    : w_head[DATA_W-1:0];
    assign status        = status_q;

endmodule
`default_nettype wire

// File: tb/tb_coef_update_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_coef_update_rx
// Desc    : Scenario bench for coef_update_rx with a write-port scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_coef_update_rx;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [8:0]  update_control;
    logic [15:0] update_value;
    logic        coef_wr_valid;
    logic        coef_wr_ready;
    logic [1:0]  coef_wr_axis;
    logic [1:0]  coef_wr_bank;
    logic [3:0]  coef_wr_tap;
    logic [15:0] coef_wr_data;
    logic [7:0]  status;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          wr_count  = 0;
    int          run_len   = 0;
    int          max_run   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_got;
    logic [23:0] mon_exp;
    logic        tog;

    coef_update_rx #(
        .FIFO_DEPTH (4),
        .DATA_W     (16),
        .TAP_W      (4)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .update_control (update_control),
        .update_value   (update_value),
        .coef_wr_valid  (coef_wr_valid),
        .coef_wr_ready  (coef_wr_ready),
        .coef_wr_axis   (coef_wr_axis),
        .coef_wr_bank   (coef_wr_bank),
        .coef_wr_tap    (coef_wr_tap),
        .coef_wr_data   (coef_wr_data),
        .status         (status)
    );

    always #5 clk_clk = ~clk_clk;

    // Handshake seen here is taken by the DUT at the next rising edge.
    always begin
        @(negedge clk_clk);
        #2;
        if (!reset_reset && coef_wr_valid && coef_wr_ready) begin
            mon_got = {coef_wr_axis, coef_wr_bank, coef_wr_tap, coef_wr_data};
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected got=%h expected=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL write_data got=%h expected=%h", mon_got, mon_exp);
                else
                    pass_cnt++;
            end
            wr_count++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic send_event(input logic [1:0] ax, input logic [1:0] bk,
                              input logic [3:0] tp, input logic [15:0] v, input bit expect_wr);
        @(negedge clk_clk);
        tog            = ~tog;
        update_value   = v;
        update_control = {tog, ax, bk, tp};
        if (expect_wr) exp_q.push_back({ax, bk, tp, v});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !coef_wr_valid) break;
            @(negedge clk_clk);
        end
        total_cnt++;
        if (exp_q.size() != 0 || coef_wr_valid)
            $display("FAIL drain_timeout pending=%0d valid=%b expected pending=0 valid=0",
                     exp_q.size(), coef_wr_valid);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        reset_reset    = 1'b1;
        update_control = 9'h100;
        update_value   = 16'h0000;
        coef_wr_ready  = 1'b1;
        tog            = 1'b1;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (4) @(negedge clk_clk);
        total_cnt++;
        if (coef_wr_valid !== 1'b0) $display("FAIL prime_valid got=%b expected=0", coef_wr_valid);
        else pass_cnt++;
        total_cnt++;
        if (status !== 8'h00) $display("FAIL prime_status got=%h expected=00", status);
        else pass_cnt++;
        total_cnt++;
        if ({coef_wr_axis, coef_wr_bank, coef_wr_tap, coef_wr_data} !== 24'h0)
            $display("FAIL reset_outputs got=%h expected=000000",
                     {coef_wr_axis, coef_wr_bank, coef_wr_tap, coef_wr_data});
        else pass_cnt++;

        send_event(2'd0, 2'd0, 4'd0, 16'h1234, 1'b1);
        @(negedge clk_clk);
        total_cnt++;
        if (coef_wr_valid !== 1'b0) $display("FAIL latency_early got=%b expected=0", coef_wr_valid);
        else pass_cnt++;
        @(negedge clk_clk);
        total_cnt++;
        if (coef_wr_valid !== 1'b1) $display("FAIL latency_valid got=%b expected=1", coef_wr_valid);
        else pass_cnt++;
        wait_drain();
    endtask

    task automatic test_overflow();
        int wc;
        coef_wr_ready = 1'b0;
        wc = wr_count;
        for (int i = 0; i < 5; i++)
            send_event(2'd1, 2'd2, 4'(i), 16'(i + 1), i < 4);
        repeat (4) @(negedge clk_clk);
        total_cnt++;
        if (status !== 8'h89) $display("FAIL overflow_status got=%h expected=89", status);
        else pass_cnt++;
        total_cnt++;
        if (coef_wr_valid !== 1'b1 || coef_wr_data !== 16'd1)
            $display("FAIL overflow_head got=%b/%h expected=1/0001", coef_wr_valid, coef_wr_data);
        else pass_cnt++;
        coef_wr_ready = 1'b1;
        wait_drain();
        total_cnt++;
        if (wr_count - wc != 4) $display("FAIL overflow_count got=%0d expected=4", wr_count - wc);
        else pass_cnt++;
        repeat (2) @(negedge clk_clk);
        total_cnt++;
        if (status !== 8'h80) $display("FAIL overflow_sticky got=%h expected=80", status);
        else pass_cnt++;
    endtask

    task automatic test_full_pop();
        int wc;
        send_event(2'd3, 2'd0, 4'd15, 16'h0000, 1'b0);
        repeat (3) @(negedge clk_clk);
        total_cnt++;
        if (status !== 8'h00) $display("FAIL clear_ovf got=%h expected=00", status);
        else pass_cnt++;
        coef_wr_ready = 1'b0;
        wc = wr_count;
        for (int i = 0; i < 4; i++)
            send_event(2'd0, 2'd1, 4'(i), 16'(10 + i), 1'b1);
        repeat (3) @(negedge clk_clk);
        total_cnt++;
        if (status !== 8'h09) $display("FAIL full_status got=%h expected=09", status);
        else pass_cnt++;
        send_event(2'd0, 2'd1, 4'd4, 16'd14, 1'b1);
        @(negedge clk_clk);
        coef_wr_ready = 1'b1;
        @(negedge clk_clk);
        coef_wr_ready = 1'b0;
        repeat (3) @(negedge clk_clk);
        total_cnt++;
        if (status !== 8'h09) $display("FAIL full_pop_status got=%h expected=09", status);
        else pass_cnt++;
        coef_wr_ready = 1'b1;
        wait_drain();
        total_cnt++;
        if (wr_count - wc != 5) $display("FAIL full_pop_count got=%0d expected=5", wr_count - wc);
        else pass_cnt++;
    endtask

    task automatic test_command();
        send_event(2'd3, 2'd0, 4'd5, 16'h0000, 1'b0);
        repeat (3) @(negedge clk_clk);
        total_cnt++;
        if (status !== 8'h40 || coef_wr_valid !== 1'b0)
            $display("FAIL cmd_reserved got=%h/%b expected=40/0", status, coef_wr_valid);
        else pass_cnt++;
        send_event(2'd3, 2'd0, 4'd15, 16'h0000, 1'b0);
        repeat (3) @(negedge clk_clk);
        total_cnt++;
        if (status !== 8'h00 || coef_wr_valid !== 1'b0)
            $display("FAIL cmd_clear got=%h/%b expected=00/0", status, coef_wr_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int wc;
        coef_wr_ready = 1'b0;
        for (int i = 1; i <= 3; i++)
            send_event(2'd0, 2'd0, 4'(i), 16'(16'h20 + i), 1'b0);
        repeat (3) @(negedge clk_clk);
        total_cnt++;
        if (status !== 8'h07) $display("FAIL mid_level got=%h expected=07", status);
        else pass_cnt++;
        @(negedge clk_clk);
        #3 reset_reset = 1'b1;
        #1;
        total_cnt++;
        if (coef_wr_valid !== 1'b0 || status !== 8'h00 || coef_wr_data !== 16'h0)
            $display("FAIL mid_reset got=%b/%h/%h expected=0/00/0000",
                     coef_wr_valid, status, coef_wr_data);
        else pass_cnt++;
        repeat (2) @(negedge clk_clk);
        reset_reset   = 1'b0;
        coef_wr_ready = 1'b1;
        repeat (4) @(negedge clk_clk);
        total_cnt++;
        if (coef_wr_valid !== 1'b0 || status !== 8'h00)
            $display("FAIL mid_reprime got=%b/%h expected=0/00", coef_wr_valid, status);
        else pass_cnt++;
        wc = wr_count;
        send_event(2'd2, 2'd1, 4'd7, 16'hBEEF, 1'b1);
        wait_drain();
        total_cnt++;
        if (wr_count - wc != 1) $display("FAIL mid_single got=%0d expected=1", wr_count - wc);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int wc;
        coef_wr_ready = 1'b1;
        wc      = wr_count;
        max_run = 0;
        for (int i = 0; i < 4; i++)
            send_event(2'd2, 2'd3, 4'(12 + i), 16'(16'h0C00 + i), 1'b1);
        wait_drain();
        total_cnt++;
        if (wr_count - wc != 4) $display("FAIL b2b_count got=%0d expected=4", wr_count - wc);
        else pass_cnt++;
        total_cnt++;
        if (max_run != 4) $display("FAIL b2b_consecutive got=%0d expected=4", max_run);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_full_pop();
        test_command();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk_clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
